// File: rtl/tr_bank.sv
// rtl/tr_bank.sv - bank of temp registers with load, increment and registered read
// Optional TR_BANK_BYPASS_EN forwards a same-cycle update to the read port.
module tr_bank #(
  parameter int DIN_W  = 9,
  parameter int DOUT_W = 18,
  parameter int DEPTH  = 4,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              write,
  input  logic              inc,
  input  logic              read,
  input  logic [AW-1:0]     wsel,
  input  logic [AW-1:0]     rsel,
  input  logic [DIN_W-1:0]  din,
  output logic [DOUT_W-1:0] dout,
  output logic              dvalid,
  output logic              rd_unwritten
);

  logic [DOUT_W-1:0] entry [DEPTH];
  logic [DEPTH-1:0]  written;

  logic              upd_en;
  logic [DOUT_W-1:0] upd_val;
  logic [DOUT_W-1:0] rd_data;
  logic              rd_written;

  assign upd_en = write | inc;

  // Load wins over increment when both are requested.
  always_comb begin
    upd_val = '0;
    if (write) begin
      upd_val[DIN_W-1:0] = din;
    end else begin
      upd_val = entry[wsel] + DOUT_W'(1);
    end
  end

  always_comb begin
    rd_data    = entry[rsel];
    rd_written = written[rsel];
`ifdef TR_BANK_BYPASS_EN
    if (upd_en && (rsel == wsel)) begin
      rd_data    = upd_val;
      rd_written = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        entry[i] <= '0;
      end
      written      <= '0;
      dout         <= '0;
      dvalid       <= 1'b0;
      rd_unwritten <= 1'b0;
    end else begin
      if (upd_en) begin
        entry[wsel]   <= upd_val;
        written[wsel] <= 1'b1;
      end
      dvalid <= read;
      if (read) begin
        dout         <= rd_data;
        rd_unwritten <= ~rd_written;
      end
    end
  end

endmodule
